// File: rtl/sram_burst_ctrl.sv
// Burst read/write sequencer driving the 32x8 register-file SRAM pins.
// Define SRAM_CLEAR_EN to add a post-reset sweep writing CLEAR_VALUE to every word.
module sram_burst_ctrl #(
    parameter int            AW          = 5,
    parameter int            DW          = 8,
    parameter int            LW          = 3,
    parameter logic [DW-1:0] CLEAR_VALUE = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic [AW-1:0] sram_address,
    output logic          sram_wr_rd,
    output logic [DW-1:0] sram_data_in,
    input  logic [DW-1:0] sram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
`ifdef SRAM_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cur_addr, addr_nx;
    logic [LW-1:0] beats, beats_nx;

    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef SRAM_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            cur_addr <= '0;
            beats    <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            cur_addr <= addr_nx;
            beats    <= beats_nx;
            rd_valid <= (state == READ);
            rd_last  <= (state == READ) && (beats == '0);
            if (state == READ)
                rd_data <= sram_data_out;
        end
    end

    // While reset is held, every pin output is forced quiet so nothing reaches the SRAM.
    always_comb begin
        state_nx     = state;
        addr_nx      = cur_addr;
        beats_nx     = beats;
        req_ready    = 1'b0;
        wr_ready     = 1'b0;
        busy         = (state != IDLE);
        sram_wr_rd   = 1'b0;
        sram_address = '0;
        sram_data_in = '0;
        if (reset) begin
            sram_address = cur_addr;
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        addr_nx  = req_addr;
                        beats_nx = req_len;
                        state_nx = req_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    wr_ready     = 1'b1;
                    sram_data_in = wr_data;
                    sram_wr_rd   = wr_valid;
                    if (wr_valid) begin
                        addr_nx  = cur_addr + AW'(1);
                        beats_nx = beats - LW'(1);
                        if (beats == '0)
                            state_nx = IDLE;
                    end
                end
                READ: begin
                    addr_nx  = cur_addr + AW'(1);
                    beats_nx = beats - LW'(1);
                    if (beats == '0)
                        state_nx = IDLE;
                end
`ifdef SRAM_CLEAR_EN
                CLEAR: begin
                    sram_wr_rd   = 1'b1;
                    sram_data_in = CLEAR_VALUE;
                    addr_nx      = cur_addr + AW'(1);
                    if (&cur_addr)
                        state_nx = IDLE;
                end
`endif
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural 32x8 SRAM attached to its pins.
module tb_sram_burst_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_we;
    logic [4:0] req_addr;
    logic [2:0] req_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_last, busy;
    logic [7:0] rd_data;
    logic [4:0] sram_address;
    logic       sram_wr_rd;
    logic [7:0] sram_data_in, sram_data_out;

    logic [7:0] mem [32];
    int         wcnt;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
        .sram_address(sram_address), .sram_wr_rd(sram_wr_rd),
        .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
    );

    // SRAM: write at the clock edge, combinational read.
    assign sram_data_out = mem[sram_address];
    always @(posedge clk) begin
        if (sram_wr_rd) begin
            mem[sram_address] <= sram_data_in;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let it be accepted at the next edge.
    task automatic issue(input logic we, input logic [4:0] a, input logic [2:0] l);
        req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [4:0] a, input logic [2:0] l, input logic [7:0] d [8], input int gap);
        logic [4:0] ea;
        issue(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    wr_valid = 1'b0;
                    @(negedge clk);
                    chk("gap_no_write", sram_wr_rd, 1'b0);
                    chk("gap_busy", busy, 1'b1);
                    tick();
                end
            end
            wr_valid = 1'b1; wr_data = d[i];
            ea = a + 5'(i);
            @(negedge clk);
            chk("wr_ready", wr_ready, 1'b1);
            chk("wr_en", sram_wr_rd, 1'b1);
            chk("wr_addr", sram_address, ea);
            chk("wr_data", sram_data_in, d[i]);
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_req_ready", req_ready, 1'b1);
        tick();
    endtask

    // Starts right after the accepting edge; ends after the idle cycle carrying the last beat.
    task automatic rd_collect(input logic [2:0] l, input logic [7:0] d [8]);
        @(negedge clk);
        chk("rd_latency", rd_valid, 1'b0);
        chk("rd_no_write", sram_wr_rd, 1'b0);
        tick();
        for (int i = 0; i <= int'(l); i++) begin
            @(negedge clk);
            chk("rd_valid", rd_valid, 1'b1);
            chk("rd_data", rd_data, d[i]);
            chk("rd_last", rd_last, (i == int'(l)));
            if (i == int'(l)) chk("rd_last_idle", busy, 1'b0);
            tick();
        end
        @(negedge clk);
        chk("rd_after_last", rd_valid, 1'b0);
        tick();
    endtask

    logic [7:0] da [8], db [8], dc [8], dz [8];
    int n;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h5a;
        wcnt = 0;
        da = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0};
        db = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
        dc = '{8'hC5, 8'hC6, 0, 0, 0, 0, 0, 0};
        dz = '{default: 8'h00};
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_wr_rd", sram_wr_rd, 1'b0);
        chk("rst_addr", sram_address, 5'd0);
        chk("rst_din", sram_data_in, 8'h00);
        tick();
        reset = 1'b1;
`ifdef SRAM_CLEAR_EN
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        chk("init_clear_done", busy, 1'b0);
        wcnt = 0;
`else
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        tick();
`endif

        // 1: write 5..8 then read back
        wr_burst(5'd5, 3'd3, da, 0);
        chk("t1_wcnt", wcnt, 4);
        chk("t1_mem8", mem[8], 8'hA3);
        issue(1'b0, 5'd5, 3'd3);
        rd_collect(3'd3, da);

        // 2: address wrap 30,31,0,1
        wr_burst(5'd30, 3'd3, db, 0);
        chk("t2_mem0", mem[0], 8'h33);
        chk("t2_mem1", mem[1], 8'h44);
        issue(1'b0, 5'd30, 3'd3);
        rd_collect(3'd3, db);

        // 3: stalled write, exactly two writes
        n = wcnt;
        wr_burst(5'd12, 3'd1, dc, 3);
        chk("t3_wcnt", wcnt - n, 2);
        chk("t3_mem13", mem[13], 8'hC6);

        // 4: request held during a read burst
        issue(1'b0, 5'd5, 3'd3);
        req_valid = 1'b1; req_addr = 5'd30; req_len = 3'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_req_ready_busy", req_ready, 1'b0);
            if (k > 0) chk("t4_rd_data", rd_data, da[k-1]);
            tick();
        end
        @(negedge clk);
        chk("t4_req_ready_idle", req_ready, 1'b1);
        chk("t4_last_beat", rd_last, 1'b1);
        chk("t4_last_data", rd_data, 8'hA3);
        tick();
        req_valid = 1'b0;
        rd_collect(3'd3, db);

        // 5: reset after beat 1 of a len=7 read
        issue(1'b0, 5'd0, 3'd7);
        tick();
        tick();
        @(negedge clk);
        chk("t5_beat1", rd_data, 8'h44);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rd_valid) n++;
`ifndef SRAM_CLEAR_EN
            chk("t5_busy", busy, 1'b0);
`endif
            tick();
        end
        chk("t5_no_beats", n, 0);

`ifdef SRAM_CLEAR_EN
        // 6: clear sweep; three cycles already spent above
        n = 3;
        while (busy && n < 100) begin n++; tick(); end
        chk("t6_clear_cycles", n, 32);
        for (int b = 0; b < 4; b++) begin
            issue(1'b0, 5'(b * 8), 3'd7);
            rd_collect(3'd7, dz);
        end
`else
        issue(1'b0, 5'd12, 3'd1);
        rd_collect(3'd1, dc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 exp 1");
        $fatal(1);
    end

endmodule
